// File: rtl/regfile_seq.sv
// Register-file load sequencer: loads A, B and OP into a register file, optionally reads one back,
// then pulses done. Outputs are registered and describe the state being entered.
module regfile_seq #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_a_src,
  input  logic          cmd_b_src,
  input  logic [DW-1:0] cmd_imm_a,
  input  logic [DW-1:0] cmd_imm_b,
  input  logic [DW-1:0] cmd_op,
  input  logic [1:0]    cmd_rd,
  input  logic          stall,
  output logic [2:0]    rs,
  output logic [1:0]    ws,
  output logic [DW-1:0] imm,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_A  = 3'd1,
    S_LD_B  = 3'd2,
    S_LD_OP = 3'd3,
    S_RD    = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_b_src;
  logic [DW-1:0] r_imm_b;
  logic [DW-1:0] r_op;
  logic [1:0]    r_rd;
  logic [2:0]    r_rs;
  logic [1:0]    r_ws;
  logic [DW-1:0] r_imm;
  logic [2:0]    w_rs;
  logic [1:0]    w_ws;
  logic [DW-1:0] w_imm;
  logic          w_adv;
  logic          w_accept;

  // IDLE always advances so a stall never blocks acceptance.
  assign w_adv    = (r_state == S_IDLE) || !stall;
  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_LD_A;
      S_LD_A:  w_next = S_LD_B;
      S_LD_B:  w_next = S_LD_OP;
      S_LD_OP: w_next = (r_rd != 2'b00) ? S_RD : S_FIN;
      S_RD:    w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // LD_A is only entered on the acceptance edge, so the A fields are taken
  // straight from the command inputs and never need their own latch.
  always_comb begin
    w_rs  = '0;
    w_ws  = '0;
    w_imm = '0;
    case (w_next)
      S_LD_A: begin
        if (cmd_a_src) begin
          w_rs = 3'b010;
        end else begin
          w_rs  = 3'b001;
          w_imm = cmd_imm_a;
        end
      end
      S_LD_B: begin
        if (r_b_src) begin
          w_rs = 3'b100;
        end else begin
          w_rs  = 3'b011;
          w_imm = r_imm_b;
        end
      end
      S_LD_OP: begin
        w_rs  = 3'b101;
        w_imm = r_op;
      end
      S_RD:    w_ws = r_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rs    <= '0;
      r_ws    <= '0;
      r_imm   <= '0;
      r_b_src <= 1'b0;
      r_imm_b <= '0;
      r_op    <= '0;
      r_rd    <= '0;
    end else if (w_adv) begin
      r_state <= w_next;
      r_rs    <= w_rs;
      r_ws    <= w_ws;
      r_imm   <= w_imm;
      if (w_accept) begin
        r_b_src <= cmd_b_src;
        r_imm_b <= cmd_imm_b;
        r_op    <= cmd_op;
        r_rd    <= cmd_rd;
      end
    end
  end

  assign rs        = r_rs;
  assign ws        = r_ws;
  assign imm       = r_imm;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: accepted commands queue their expected output
// steps; a negedge monitor checks every cycle, repeating a step while stall is held.
module tb_regfile_seq;
  localparam int DW = 4;

  typedef logic [DW+5:0] tup_t;  // {done, rs, ws, imm}
  typedef struct packed {
    logic [2:0]      n;
    logic [4:0][DW+5:0] s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_a_src, cmd_b_src, stall;
  logic [DW-1:0] cmd_imm_a, cmd_imm_b, cmd_op, imm;
  logic [1:0]    cmd_rd, ws;
  logic [2:0]    rs;
  logic          busy, done;

  int unsigned checks = 0;
  int unsigned failures = 0;
  exp_t        q[$];
  int unsigned idx = 0;
  logic        m_idle = 1'b1;

  regfile_seq #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_src(cmd_a_src), .cmd_b_src(cmd_b_src), .cmd_imm_a(cmd_imm_a),
    .cmd_imm_b(cmd_imm_b), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .stall(stall),
    .rs(rs), .ws(ws), .imm(imm), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected sequence of per-state outputs for one command.
  function automatic exp_t build(input logic a, input logic b, input logic [DW-1:0] ia,
                                 input logic [DW-1:0] ib, input logic [DW-1:0] op,
                                 input logic [1:0] rd);
    exp_t e;
    int unsigned k;
    logic [DW-1:0] z;
    e = '0;
    z = '0;
    k = 0;
    e.s[k] = a ? {1'b0, 3'b010, 2'b00, z} : {1'b0, 3'b001, 2'b00, ia}; k++;
    e.s[k] = b ? {1'b0, 3'b100, 2'b00, z} : {1'b0, 3'b011, 2'b00, ib}; k++;
    e.s[k] = {1'b0, 3'b101, 2'b00, op}; k++;
    if (rd != 2'b00) begin
      e.s[k] = {1'b0, 3'b000, rd, z}; k++;
    end
    e.s[k] = {1'b1, 3'b000, 2'b00, z}; k++;
    e.n = 3'(k);
    return e;
  endfunction

  // Monitor: m_idle captures whether the sequencer should accept at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      idx = 0;
      m_idle = 1'b1;
    end else begin
      m_idle = (q.size() == 0);
      check("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_idle});
      check("busy", {31'b0, busy}, {31'b0, !m_idle});
      check("rs_range", {31'b0, (rs <= 3'd5)}, 32'd1);
      check("rs_ws_excl", {31'b0, !((rs != 3'd0) && (ws != 2'd0))}, 32'd1);
      if (q.size() != 0) begin
        check("step", 32'({done, rs, ws, imm}), 32'(q[0].s[idx]));
        if (!stall) begin
          idx++;
          if (idx == 32'(q[0].n)) begin
            void'(q.pop_front());
            idx = 0;
          end
        end
      end else begin
        check("idle_out", 32'({done, rs, ws, imm}), 32'd0);
      end
    end
  end

  task automatic cyc(input logic v, input logic a, input logic b, input logic [DW-1:0] ia,
                     input logic [DW-1:0] ib, input logic [DW-1:0] op, input logic [1:0] rd,
                     input logic st);
    @(posedge clk);
    if (rst_n && cmd_valid && m_idle)
      q.push_back(build(cmd_a_src, cmd_b_src, cmd_imm_a, cmd_imm_b, cmd_op, cmd_rd));
    #1;
    cmd_valid = v; cmd_a_src = a; cmd_b_src = b; cmd_imm_a = ia;
    cmd_imm_b = ib; cmd_op = op; cmd_rd = rd; stall = st;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic rnd(input logic v, input logic st);
    cyc(v, 1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
        2'($urandom), st);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a_src = 1'b0; cmd_b_src = 1'b0;
    cmd_imm_a = '0; cmd_imm_b = '0; cmd_op = '0; cmd_rd = '0; stall = 1'b0;
    #3;
    check("rst_rs", 32'(rs), 32'd0);
    check("rst_ws_imm", 32'({ws, imm}), 32'd0);
    check("rst_busy_done", {30'b0, busy, done}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // imm sources, rd = 00: 001/3, 011/5, 101/9, done
    cyc(1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 4'd9, 2'b00, 1'b0);
    idle(6);
    // bus sources, rd = 11: 010, 100, 101, ws=11, done
    cyc(1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 4'd2, 2'b11, 1'b0);
    idle(7);
    // stall two cycles in LD_B
    cyc(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    idle(8);
    // cmd_valid held high with changing fields while busy
    for (int unsigned i = 0; i < 14; i++) rnd(1'b1, 1'b0);
    idle(8);
    // stall in IDLE must not block acceptance
    cyc(1'b1, 1'b0, 1'b1, 4'd6, 4'd8, 4'd10, 2'b01, 1'b1);
    idle(8);
    // stall two cycles in FIN stretches done
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 4'd15, 4'd12, 2'b00, 1'b0);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    idle(6);
    // asynchronous reset during LD_OP
    cyc(1'b1, 1'b0, 1'b1, 4'd4, 4'd5, 4'd6, 2'b01, 1'b0);
    idle(3);
    check("pre_rst_rs", 32'(rs), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", 32'({done, rs, ws, imm}), 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4);
    // randomized traffic
    for (int unsigned i = 0; i < 400; i++)
      rnd(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    idle(20);
    check("drain", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
